// File: rtl/cprv_decode_stage.sv
// RV64I decode stage: decode, immediates, operand read, pending-write scoreboard, valid/ready EX register.
// Optional write-back bypass into operands and hazard check: define CPRV_ID_WB_BYPASS_EN.
module cprv_decode_stage #(
  parameter int INSTR_WIDTH = 32,
  parameter int DATA_WIDTH  = 64,
  parameter int IMM_WIDTH   = 64,
  parameter int PC_WIDTH    = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_id_i,
  output logic                   ready_id_o,
  input  logic [INSTR_WIDTH-1:0] instr_data_id_i,
  input  logic [PC_WIDTH-1:0]    pc_id_i,
  input  logic                   flush_i,
  output logic                   valid_ex_o,
  input  logic                   ready_ex_i,
  output logic [DATA_WIDTH-1:0]  rs1_data_ex_o,
  output logic [DATA_WIDTH-1:0]  rs2_data_ex_o,
  output logic [IMM_WIDTH-1:0]   imm_data_ex_o,
  output logic [PC_WIDTH-1:0]    pc_ex_o,
  output logic [4:0]             rd_addr_ex_o,
  output logic                   rd_en_ex_o,
  output logic [6:0]             opcode_ex_o,
  output logic [2:0]             funct3_ex_o,
  output logic [6:0]             funct7_ex_o,
  output logic                   mem_r_en_ex_o,
  output logic                   mem_w_en_ex_o,
  output logic                   illegal_ex_o,
  output logic [4:0]             rs1_addr_wb_o,
  output logic [4:0]             rs2_addr_wb_o,
  input  logic [DATA_WIDTH-1:0]  rs1_data_wb_i,
  input  logic [DATA_WIDTH-1:0]  rs2_data_wb_i,
  input  logic                   wb_en_i,
  input  logic [4:0]             wb_addr_i,
  input  logic [DATA_WIDTH-1:0]  wb_data_i
);

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;

  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd_addr, rs1_addr, rs2_addr;
  logic        rd_en_dec, rs1_used, rs2_used, mem_r_dec, mem_w_dec, illegal_dec;
  logic [31:0] imm32;
  logic [IMM_WIDTH-1:0] imm_ext;
  logic [31:0] pending, pending_next;
  logic        hazard, cke, take;
  logic        byp1, byp2;
  logic [DATA_WIDTH-1:0] rs1_op, rs2_op;

  assign instr    = instr_data_id_i[31:0];
  assign opcode   = instr[6:0];
  assign rd_addr  = instr[11:7];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];
  assign rs1_addr_wb_o = rs1_addr;
  assign rs2_addr_wb_o = rs2_addr;

  // Full 7-bit opcode compare also rejects encodings whose low two bits are not 2'b11.
  always_comb begin
    rd_en_dec   = 1'b0;
    rs1_used    = 1'b0;
    rs2_used    = 1'b0;
    mem_r_dec   = 1'b0;
    mem_w_dec   = 1'b0;
    illegal_dec = 1'b0;
    imm32       = 32'd0;
    case (opcode)
      OPC_OP, OPC_OP_32: begin
        rd_en_dec = 1'b1;
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
      end
      OPC_OP_IMM, OPC_OP_IMM_32, OPC_JALR: begin
        rd_en_dec = 1'b1;
        rs1_used  = 1'b1;
        imm32     = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_LOAD: begin
        rd_en_dec = 1'b1;
        rs1_used  = 1'b1;
        mem_r_dec = 1'b1;
        imm32     = {{20{instr[31]}}, instr[31:20]};
      end
      OPC_STORE: begin
        rs1_used  = 1'b1;
        rs2_used  = 1'b1;
        mem_w_dec = 1'b1;
        imm32     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OPC_BRANCH: begin
        rs1_used = 1'b1;
        rs2_used = 1'b1;
        imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        rd_en_dec = 1'b1;
        imm32     = {instr[31:12], 12'd0};
      end
      OPC_JAL: begin
        rd_en_dec = 1'b1;
        imm32     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: illegal_dec = 1'b1;
    endcase
    if (rd_addr == 5'd0) rd_en_dec = 1'b0;
  end

  assign imm_ext = {{(IMM_WIDTH-32){imm32[31]}}, imm32};

`ifdef CPRV_ID_WB_BYPASS_EN
  // A write-back landing this cycle both supplies the operand and releases the hazard.
  assign byp1   = wb_en_i && (wb_addr_i == rs1_addr) && (rs1_addr != 5'd0) && rs1_used;
  assign byp2   = wb_en_i && (wb_addr_i == rs2_addr) && (rs2_addr != 5'd0) && rs2_used;
  assign rs1_op = byp1 ? wb_data_i : rs1_data_wb_i;
  assign rs2_op = byp2 ? wb_data_i : rs2_data_wb_i;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_data_i;
  assign byp1   = 1'b0;
  assign byp2   = 1'b0;
  assign rs1_op = rs1_data_wb_i;
  assign rs2_op = rs2_data_wb_i;
`endif

  assign hazard = (rs1_used & pending[rs1_addr] & ~byp1) |
                  (rs2_used & pending[rs2_addr] & ~byp2);
  assign cke        = ~valid_ex_o | ready_ex_i;
  assign ready_id_o = flush_i | (cke & ~hazard);
  assign take       = valid_id_i & ready_id_o & ~flush_i;

  // Clear from write-back first so a same-cycle set of the same register wins.
  always_comb begin
    pending_next = pending;
    if (wb_en_i) pending_next[wb_addr_i] = 1'b0;
    if (take && rd_en_dec) pending_next[rd_addr] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pending <= 32'd0;
    else        pending <= pending_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_ex_o    <= 1'b0;
      rs1_data_ex_o <= '0;
      rs2_data_ex_o <= '0;
      imm_data_ex_o <= '0;
      pc_ex_o       <= '0;
      rd_addr_ex_o  <= 5'd0;
      rd_en_ex_o    <= 1'b0;
      opcode_ex_o   <= 7'd0;
      funct3_ex_o   <= 3'd0;
      funct7_ex_o   <= 7'd0;
      mem_r_en_ex_o <= 1'b0;
      mem_w_en_ex_o <= 1'b0;
      illegal_ex_o  <= 1'b0;
    end else begin
      if (flush_i)  valid_ex_o <= 1'b0;
      else if (cke) valid_ex_o <= take;
      if (cke) begin
        rs1_data_ex_o <= rs1_op;
        rs2_data_ex_o <= rs2_op;
        imm_data_ex_o <= imm_ext;
        pc_ex_o       <= pc_id_i;
        rd_addr_ex_o  <= rd_addr;
        rd_en_ex_o    <= rd_en_dec;
        opcode_ex_o   <= opcode;
        funct3_ex_o   <= instr[14:12];
        funct7_ex_o   <= instr[31:25];
        mem_r_en_ex_o <= mem_r_dec;
        mem_w_en_ex_o <= mem_w_dec;
        illegal_ex_o  <= illegal_dec;
      end
    end
  end

endmodule
